// File: rtl/stepper_sequencer_if.sv
// Command channel between the host register file and one stepper_sequencer.
// The host side drives the motion command; the sequencer answers with ready.
interface stepper_sequencer_if #(
    parameter int DIV_W   = 16,
    parameter int STEPS_W = 10
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_dir;
    logic               cmd_half;
    logic [STEPS_W-1:0] cmd_steps;
    logic [DIV_W-1:0]   cmd_period;

    modport master (
        output cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_dir, cmd_half, cmd_steps, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/stepper_sequencer.sv
// Stepper motor sequencer: times steps from a host motion command, walks the
// 8-entry phase table, tracks signed position and releases coils after an idle hold.
module stepper_sequencer #(
    parameter int          DIV_W       = 16,
    parameter int          STEPS_W     = 10,
    parameter int          POS_W       = 16,
    parameter int unsigned HOLD_CYCLES = 1000000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    stepper_sequencer_if.slave   cmd,
    input  logic                 abort,
    output logic [3:0]           phase,
    output logic                 busy,
    output logic                 done,
    output logic [POS_W-1:0]     pos
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST =
        HOLD_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic               energized_q, energized_d;
    logic               done_q, done_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               dir_q, dir_d;
    logic               half_q, half_d;
    logic [STEPS_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0]   period_q, period_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;

    logic               accept;
    logic [DIV_W-1:0]   period_eff;
    logic [2:0]         idx_step;
    logic [POS_W-1:0]   pos_step;

    always_comb begin
        accept     = cmd.cmd_valid && (state_q == S_IDLE);
        period_eff = (cmd.cmd_period == '0) ? DIV_W'(1) : cmd.cmd_period;
        idx_step   = half_q ? 3'd1 : 3'd2;
        pos_step   = half_q ? POS_W'(1) : POS_W'(2);

        state_d     = state_q;
        idx_d       = idx_q;
        energized_d = energized_q;
        done_d      = 1'b0;
        pos_d       = pos_q;
        dir_d       = dir_q;
        half_d      = half_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    hold_d = '0;
                    if (cmd.cmd_steps != '0) begin
                        dir_d       = cmd.cmd_dir;
                        half_d      = cmd.cmd_half;
                        remaining_d = cmd.cmd_steps;
                        period_d    = period_eff;
                        cnt_d       = period_eff;
                        energized_d = 1'b1;
                        // Full-step only visits the odd, two-coil table entries.
                        if (!cmd.cmd_half) begin
                            idx_d = idx_q | 3'd1;
                        end
                        state_d = S_WAIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (energized_q && (HOLD_CYCLES != 0)) begin
                    if (hold_q == HOLD_LAST) begin
                        energized_d = 1'b0;
                        hold_d      = '0;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // abort takes priority over a step falling on the same edge.
                if (abort) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == DIV_W'(1)) begin
                    idx_d       = dir_q ? (idx_q + idx_step) : (idx_q - idx_step);
                    pos_d       = dir_q ? (pos_q + pos_step) : (pos_q - pos_step);
                    remaining_d = remaining_q - STEPS_W'(1);
                    hold_d      = '0;
                    if (remaining_q == STEPS_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = period_q;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            energized_q <= 1'b0;
            done_q      <= 1'b0;
            pos_q       <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            remaining_q <= '0;
            period_q    <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            energized_q <= energized_d;
            done_q      <= done_d;
            pos_q       <= pos_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
        end
    end

    always_comb begin
        phase = 4'b0000;
        if (energized_q) begin
            case (idx_q)
                3'd0: phase = 4'b0001;
                3'd1: phase = 4'b0011;
                3'd2: phase = 4'b0010;
                3'd3: phase = 4'b0110;
                3'd4: phase = 4'b0100;
                3'd5: phase = 4'b1100;
                3'd6: phase = 4'b1000;
                3'd7: phase = 4'b1001;
                default: phase = 4'b0000;
            endcase
        end
    end

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign pos           = pos_q;

endmodule

// File: tb/tb_stepper_sequencer.sv
// Directed bench for stepper_sequencer: expected phase/done events are queued with
// their cycle numbers; a monitor pops and compares whenever phase changes or done pulses.
module tb_stepper_sequencer;

    localparam int          DIV_W   = 16;
    localparam int          STEPS_W = 10;
    localparam int          POS_W   = 16;
    localparam int unsigned HOLD    = 20;

    logic             CLK   = 1'b0;
    logic             RST_N = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       phase;
    logic             busy;
    logic             done;
    logic [POS_W-1:0] pos;

    stepper_sequencer_if #(.DIV_W(DIV_W), .STEPS_W(STEPS_W)) cmd_if ();

    stepper_sequencer #(
        .DIV_W      (DIV_W),
        .STEPS_W    (STEPS_W),
        .POS_W      (POS_W),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .cmd  (cmd_if),
        .abort(abort),
        .phase(phase),
        .busy (busy),
        .done (done),
        .pos  (pos)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_vec = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_phase = 4'b0000;

    function automatic void push(input bit d, input logic [15:0] v, input int c);
        exp_t e;
        e.is_done = d;
        e.val     = v;
        e.cyc     = c;
        sb.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_cmp(input bit is_done, input logic [15:0] act);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected %s event: got 0x%0h at cycle %0d, none expected",
                     is_done ? "done" : "phase", act, cyc);
            return;
        end
        e = sb.pop_front();
        if (e.is_done != is_done || e.val !== act || e.cyc != cyc ||
            (is_done && busy !== 1'b0)) begin
            n_bad++;
            $display("FAIL %s event: got 0x%0h at cycle %0d busy=%b, want %s 0x%0h at cycle %0d",
                     is_done ? "done" : "phase", act, cyc, busy,
                     e.is_done ? "done" : "phase", e.val, e.cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (phase !== prev_phase) begin
                pop_cmp(1'b0, {12'b0, phase});
                prev_phase <= phase;
            end
            if (done === 1'b1) pop_cmp(1'b1, pos);
        end
    end

    task automatic issue(input bit dir, input bit half, input int steps, input int period,
                         output int n);
        cmd_if.cmd_dir    = dir;
        cmd_if.cmd_half   = half;
        cmd_if.cmd_steps  = STEPS_W'(steps);
        cmd_if.cmd_period = DIV_W'(period);
        cmd_if.cmd_valid  = 1'b1;
        n = -1;
        for (int i = 0; i < 200; i++) begin
            if (cmd_if.cmd_ready === 1'b1) begin
                n = cyc + 1;
                break;
            end
            @(negedge CLK);
        end
        if (n < 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept timeout: cmd_ready=%b, want 1 within 200 cycles", cmd_if.cmd_ready);
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1 cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
            #1;
        end
        check("scoreboard drained", sb.size(), 0);
    endtask

    task automatic wait_neg(input int c);
        for (int i = 0; i < 1000 && cyc != c; i++) @(negedge CLK);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " phase"}, phase, 4'b0000);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " done"}, done, 1'b0);
        check({tag, " cmd_ready"}, cmd_if.cmd_ready, 1'b1);
        check({tag, " pos"}, pos, 0);
    endtask

    task automatic do_reset(input bit expect_off);
        @(negedge CLK);
        #1 RST_N = 1'b0;
        if (expect_off) push(1'b0, 16'h0, cyc + 1);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        #1 check_reset_state("reset");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, n1, n2, m;
        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_dir    = 1'b0;
        cmd_if.cmd_half   = 1'b0;
        cmd_if.cmd_steps  = '0;
        cmd_if.cmd_period = '0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        prev_phase = phase;
        mon_en = 1'b1;
        #1 check_reset_state("initial");

        // Half-step forward 4 x 3, then coils release 20 idle cycles after done.
        issue(1'b1, 1'b1, 4, 3, n);
        push(1'b0, 16'h1, n);
        push(1'b0, 16'h3, n + 3);
        push(1'b0, 16'h2, n + 6);
        push(1'b0, 16'h6, n + 9);
        push(1'b0, 16'h4, n + 12);
        push(1'b1, 16'd4, n + 12);
        push(1'b0, 16'h0, n + 32);
        @(negedge CLK);
        check("busy during move", busy, 1'b1);
        check("cmd_ready during move", cmd_if.cmd_ready, 1'b0);
        wait_idle();

        // Re-energize from idx 4 before the first step.
        issue(1'b1, 1'b1, 1, 5, n);
        push(1'b0, 16'h4, n);
        push(1'b0, 16'hC, n + 5);
        push(1'b1, 16'd5, n + 5);
        wait_idle();

        // Full-step reverse from idx 0.
        do_reset(1'b1);
        issue(1'b0, 1'b0, 3, 1, n);
        push(1'b0, 16'h3, n);
        push(1'b0, 16'h9, n + 1);
        push(1'b0, 16'hC, n + 2);
        push(1'b0, 16'h6, n + 3);
        push(1'b1, 16'hFFFA, n + 3);
        wait_idle();

        // Zero-step command: done only.
        issue(1'b1, 1'b1, 0, 7, n);
        push(1'b1, 16'hFFFA, n);
        @(negedge CLK);
        check("steps0 busy", busy, 1'b0);
        check("steps0 phase", phase, 4'h6);
        @(negedge CLK);
        check("steps0 busy after", busy, 1'b0);
        wait_idle();

        // Period 0 behaves as period 1.
        issue(1'b1, 1'b1, 2, 0, n);
        push(1'b0, 16'h4, n + 1);
        push(1'b0, 16'hC, n + 2);
        push(1'b1, 16'hFFFC, n + 2);
        wait_idle();

        // Abort on the 3rd step edge, second command held and accepted after done.
        do_reset(1'b1);
        issue(1'b1, 1'b1, 10, 4, n1);
        push(1'b0, 16'h1, n1);
        push(1'b0, 16'h3, n1 + 4);
        push(1'b0, 16'h2, n1 + 8);
        push(1'b1, 16'd2, n1 + 12);
        n2 = 0;
        fork
            begin
                wait_neg(n1 + 11);
                abort = 1'b1;
                @(posedge CLK);
                #1 abort = 1'b0;
            end
            begin
                issue(1'b0, 1'b1, 1, 2, n2);
                push(1'b0, 16'h3, n2 + 2);
                push(1'b1, 16'd1, n2 + 2);
            end
        join
        check("back-to-back accept cycle", n2, n1 + 13);
        wait_idle();

        // Asynchronous reset mid-move.
        issue(1'b1, 1'b1, 5, 6, m);
        push(1'b0, 16'h2, m + 6);
        wait_neg(m + 8);
        #2 RST_N = 1'b0;
        push(1'b0, 16'h0, m + 9);
        #1 check_reset_state("async reset");
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_idle();
        repeat (30) @(negedge CLK);
        check("no trailing events", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
